// File: rtl/btn_repeat_ctrl.sv
// Four-button input conditioner: 2-FF sync, counter debounce, press pulse and
// optional auto-repeat per button, with simultaneous left+right pulses suppressed.
module btn_repeat_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 15000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter logic [3:0]  REPEAT_MASK     = 4'b0111,
    parameter int unsigned CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_in,
    output logic [3:0] btn_pulse,
    output logic [3:0] btn_level
);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD_DELAY,
        HELD_REPEAT,
        RELEASE_DB
    } state_t;

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] raw_pulse;
    logic [3:0] level_vec;
    logic [3:0] pulse_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        state_t           state_q, state_d;
        logic [CNT_W-1:0] timer_q, timer_d;
        logic             level_q, level_d;
        logic             raw_d;
        logic             s;

        assign s = sync2_q[gi];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                timer_q <= '0;
                level_q <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                level_q <= level_d;
            end
        end

        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            level_d = level_q;
            raw_d   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_DB;
                        timer_d = '0;
                    end
                end
                PRESS_DB: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (timer_q == DB_LAST) begin
                        state_d = HELD_DELAY;
                        timer_d = '0;
                        level_d = 1'b1;
                        raw_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + CNT_ONE;
                    end
                end
                HELD_DELAY: begin
                    if (!s) begin
                        state_d = RELEASE_DB;
                        timer_d = '0;
                    end else if (REPEAT_MASK[gi] && (timer_q == DELAY_LAST)) begin
                        state_d = HELD_REPEAT;
                        timer_d = '0;
                        raw_d   = 1'b1;
                    end else if (timer_q != DELAY_LAST) begin
                        // Masked buttons park here with the timer pinned at the delay limit.
                        timer_d = timer_q + CNT_ONE;
                    end
                end
                HELD_REPEAT: begin
                    if (!s) begin
                        state_d = RELEASE_DB;
                        timer_d = '0;
                    end else if (timer_q == PERIOD_LAST) begin
                        timer_d = '0;
                        raw_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + CNT_ONE;
                    end
                end
                RELEASE_DB: begin
                    // A release glitch returns to the hold phase silently and restarts the delay.
                    if (s) begin
                        state_d = HELD_DELAY;
                        timer_d = '0;
                    end else if (timer_q == DB_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                    end else begin
                        timer_d = timer_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign raw_pulse[gi] = raw_d;
        assign level_vec[gi] = level_q;
    end

    // Opposing moves in the same cycle cancel; down/rotate pass regardless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q <= '0;
        end else if (raw_pulse[0] && raw_pulse[1]) begin
            pulse_q <= {raw_pulse[3:2], 2'b00};
        end else begin
            pulse_q <= raw_pulse;
        end
    end

    assign btn_pulse = pulse_q;
    assign btn_level = level_vec;

endmodule
